// File: rtl/life_row_loader.sv
// Row loader for a 16x16 life core: collects sixteen 16-bit rows in arrival
// order, then publishes the whole board with its live-cell count and a
// one-cycle load pulse.
module life_row_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         row_valid,
    input  logic [15:0]  row_data,
    output logic         row_ready,
    input  logic         flush,
    output logic         load,
    output logic [255:0] data,
    output logic [8:0]   pop_count,
    output logic [7:0]   frame_count
);

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [255:0] staging;
    logic [3:0]   row_idx;
    logic [8:0]   acc;
    logic         xfer;
    logic         last_row;
    logic [4:0]   row_pop;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Reset gates the handshake directly so nothing is accepted during reset.
    assign row_ready = (state == FILL) && !flush && !reset;
    assign xfer      = row_valid && row_ready;
    assign last_row  = (row_idx == 4'd15);
    assign row_pop   = popcount16(row_data);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and load pulse; COMMIT always lasts one cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            FILL: begin
                if (xfer && last_row) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                load       = !reset;
                next_state = FILL;
            end
            default: begin
                next_state = FILL;
            end
        endcase
    end

    // Staging rows need no reset: every row is rewritten before it is published.
    always_ff @(posedge clk) begin
        if (xfer) begin
            staging[{row_idx, 4'b0000} +: 16] <= row_data;
        end
    end

    // Row index, running count and the published frame registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx     <= '0;
            acc         <= '0;
            data        <= '0;
            pop_count   <= '0;
            frame_count <= '0;
        end else begin
            if (state == COMMIT) begin
                frame_count <= frame_count + 8'd1;
            end
            if (state == FILL && flush) begin
                row_idx <= '0;
                acc     <= '0;
            end else if (xfer) begin
                if (last_row) begin
                    // Row 15 lands in the top slice straight from the input.
                    data      <= {row_data, staging[239:0]};
                    pop_count <= acc + {4'd0, row_pop};
                    row_idx   <= '0;
                    acc       <= '0;
                end else begin
                    row_idx <= row_idx + 4'd1;
                    acc     <= acc + {4'd0, row_pop};
                end
            end
        end
    end

endmodule
